// File: rtl/fexpand.sv
// ---------------------------------------------------------------------------
// fexpand
// Operand front-end of the FPU datapath. Accepts a packed IEEE-754 operand,
// classifies it, re-biases the exponent into the wider internal format,
// restores the hidden bit and normalises subnormals one bit per cycle.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   valid_i / ready_o   packed operand handshake
//   operand_i           {sign, exponent, fraction}
//   rm_i                rounding mode, carried alongside the operand
//   valid_o / ready_i   unpacked result handshake
//   exponentR           internal biased exponent (bias 2^(IEW-1)-1)
//   significantR        {hidden bit, fraction, 3'b000}
//   signR, infR, nanR, snanR, zeroR   sign and class flags
//   rmR                 rounding mode belonging to the result
// ---------------------------------------------------------------------------
module fexpand #(
   parameter int FW  = 23,
   parameter int EW  = 8,
   parameter int IFW = 26,
   parameter int IEW = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [EW+FW:0]   operand_i,
   input  logic [2:0]       rm_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [IEW-1:0]   exponentR,
   output logic [IFW:0]     significantR,
   output logic             signR,
   output logic             infR,
   output logic             nanR,
   output logic             snanR,
   output logic             zeroR,
   output logic [2:0]       rmR
);

   // Difference between the internal and packed biases.
   localparam logic [IEW-1:0] OFF     = IEW'((1 << (IEW-1)) - (1 << (EW-1)));
   localparam logic [IEW-1:0] SUB_EXP = IEW'((1 << (IEW-1)) - (1 << (EW-1)) + 1);

   typedef enum logic [1:0] {IDLE, NORM, HOLD} state_t;

   state_t          r_state;
   state_t          w_nextState;

   logic [IEW-1:0]  r_exp;
   logic [IFW:0]    r_sig;
   logic            r_sign;
   logic            r_inf;
   logic            r_nan;
   logic            r_snan;
   logic            r_zero;
   logic [2:0]      r_rm;

   logic            w_accept;
   logic [EW-1:0]   w_expField;
   logic [FW-1:0]   w_fracField;
   logic            w_signField;
   logic            w_expOnes;
   logic            w_expZero;
   logic            w_fracZero;
   logic            w_subnormal;
   logic [IEW-1:0]  w_expLoad;
   logic [IFW:0]    w_sigLoad;

   // Field split and class predicates of the incoming operand.
   assign w_signField = operand_i[EW+FW];
   assign w_expField  = operand_i[EW+FW-1:FW];
   assign w_fracField = operand_i[FW-1:0];
   assign w_expOnes   = &w_expField;
   assign w_expZero   = ~|w_expField;
   assign w_fracZero  = ~|w_fracField;
   assign w_subnormal = w_expZero & ~w_fracZero;

   // Values loaded into the exponent/significand registers at acceptance.
   // Subnormals start at OFF+1 with no hidden bit and are shifted up in NORM.
   always_comb begin
      w_expLoad = {{(IEW-EW){1'b0}}, w_expField} + OFF;
      w_sigLoad = {1'b1, w_fracField, 3'b000};
      if (w_expOnes) begin
         w_expLoad = '1;
      end else if (w_expZero) begin
         if (w_fracZero) begin
            w_expLoad = '0;
            w_sigLoad = '0;
         end else begin
            w_expLoad = SUB_EXP;
            w_sigLoad = {1'b0, w_fracField, 3'b000};
         end
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic. HOLD can accept a new operand on the same edge the
   // current result is consumed, giving one result per cycle when streaming.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (valid_i) begin
               w_nextState = w_subnormal ? NORM : HOLD;
            end
         end
         NORM: begin
            if (r_sig[IFW-1]) begin
               w_nextState = HOLD;
            end
         end
         HOLD: begin
            if (ready_i) begin
               if (valid_i) begin
                  w_nextState = w_subnormal ? NORM : HOLD;
               end else begin
                  w_nextState = IDLE;
               end
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   // Handshake outputs derived from the state.
   always_comb begin
      ready_o  = (r_state == IDLE) | ((r_state == HOLD) & ready_i);
      valid_o  = (r_state == HOLD);
      w_accept = valid_i & ready_o;
   end

   // Result registers: loaded at acceptance, shifted during NORM, otherwise
   // held so the outputs stay stable under backpressure.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_exp  <= '0;
         r_sig  <= '0;
         r_sign <= 1'b0;
         r_inf  <= 1'b0;
         r_nan  <= 1'b0;
         r_snan <= 1'b0;
         r_zero <= 1'b0;
         r_rm   <= '0;
      end else if (w_accept) begin
         r_exp  <= w_expLoad;
         r_sig  <= w_sigLoad;
         r_sign <= w_signField;
         r_inf  <= w_expOnes & w_fracZero;
         r_nan  <= w_expOnes & ~w_fracZero;
         r_snan <= w_expOnes & ~w_fracZero & ~w_fracField[FW-1];
         r_zero <= w_expZero & w_fracZero;
         r_rm   <= rm_i;
      end else if (r_state == NORM) begin
         r_sig  <= r_sig << 1;
         r_exp  <= r_exp - IEW'(1);
      end
   end

   assign exponentR    = r_exp;
   assign significantR = r_sig;
   assign signR        = r_sign;
   assign infR         = r_inf;
   assign nanR         = r_nan;
   assign snanR        = r_snan;
   assign zeroR        = r_zero;
   assign rmR          = r_rm;

endmodule
